// File: rtl/low_fir_filter.sv
// rtl/low_fir_filter.sv - low-band FIR multiply-accumulate over one sequencing burst (up to 1021 taps)
// Define LOW_FIR_SAT_EN to saturate smpl_out; otherwise acc[30:15] wraps.
module low_fir_filter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sequencing,
    input  logic [15:0] smpl_in,
    output logic [9:0]  coeff_addr,
    input  logic [15:0] coeff,
    output logic [15:0] smpl_out,
    output logic        smpl_vld
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

    localparam logic [9:0] LAST_TAP = 10'd1020;

    state_t             state, state_nxt;
    logic [9:0]         tap_cnt, tap_cnt_nxt;
    logic               full, full_nxt;
    logic               tap_take;
    logic               seq_d;
    logic               drain_cnt;
    logic               data_vld;
    logic               prod_vld;
    logic signed [31:0] prod;
    logic signed [31:0] mult;
    logic signed [41:0] acc;
    logic [15:0]        result;

    assign coeff_addr = tap_cnt;
    assign mult       = 32'($signed(smpl_in)) * 32'($signed(coeff));

    // A burst starts only on a rising edge seen in IDLE, so a level left high
    // from a burst that re-raised during DRAIN/OUT does not restart it.
    always_comb begin
        state_nxt   = state;
        tap_cnt_nxt = tap_cnt;
        full_nxt    = full;
        tap_take    = 1'b0;
        case (state)
            IDLE: begin
                tap_cnt_nxt = 10'd0;
                full_nxt    = 1'b0;
                if (sequencing && !seq_d) begin
                    tap_take    = 1'b1;
                    tap_cnt_nxt = 10'd1;
                    state_nxt   = ACCUM;
                end
            end
            ACCUM: begin
                if (!sequencing) begin
                    tap_cnt_nxt = 10'd0;
                    full_nxt    = 1'b0;
                    state_nxt   = DRAIN;
                end else if (!full) begin
                    tap_take = 1'b1;
                    if (tap_cnt == LAST_TAP) begin
                        full_nxt = 1'b1;
                    end else begin
                        tap_cnt_nxt = tap_cnt + 10'd1;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef LOW_FIR_SAT_EN
    logic signed [26:0] acc_sh;
    assign acc_sh = acc[41:15];
    always_comb begin
        result = acc_sh[15:0];
        if (acc_sh > 27'sd32767) begin
            result = 16'h7FFF;
        end else if (acc_sh < -27'sd32768) begin
            result = 16'h8000;
        end
    end
`else
    assign result = acc[30:15];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tap_cnt   <= 10'd0;
            full      <= 1'b0;
            seq_d     <= 1'b0;
            drain_cnt <= 1'b0;
            data_vld  <= 1'b0;
            prod_vld  <= 1'b0;
            prod      <= 32'sd0;
            acc       <= 42'sd0;
            smpl_out  <= 16'h0000;
            smpl_vld  <= 1'b0;
        end else begin
            state     <= state_nxt;
            tap_cnt   <= tap_cnt_nxt;
            full      <= full_nxt;
            seq_d     <= sequencing;
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            data_vld  <= tap_take;
            prod_vld  <= data_vld;
            if (data_vld) begin
                prod <= mult;
            end
            // Clearing in OUT cannot race a new product: the next burst's first
            // product lands two edges after IDLE accepts it.
            if (state == OUT) begin
                acc <= 42'sd0;
            end else if (prod_vld) begin
                acc <= acc + 42'(prod);
            end
            smpl_vld <= (state == DRAIN) && drain_cnt;
            if ((state == DRAIN) && drain_cnt) begin
                smpl_out <= result;
            end
        end
    end

endmodule

// File: tb/tb_low_fir_filter.sv
// tb/tb_low_fir_filter.sv - directed bench with burst-level reference model for low_fir_filter
module tb_low_fir_filter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sequencing = 1'b0;
    logic [15:0] smpl_in = 16'h0000;
    logic [15:0] coeff = 16'h0000;
    logic [9:0]  coeff_addr;
    logic [15:0] smpl_out;
    logic        smpl_vld;

    low_fir_filter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sequencing (sequencing),
        .smpl_in    (smpl_in),
        .coeff_addr (coeff_addr),
        .coeff      (coeff),
        .smpl_out   (smpl_out),
        .smpl_vld   (smpl_vld)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] rom [1024];
    logic [15:0] pend = 16'h0000;
    logic [15:0] dconst = 16'h0000;
    int          exp_cyc [$];
    logic [15:0] exp_val [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [15:0] scale(input longint a);
        longint s;
        s = a >>> 15;
`ifdef LOW_FIR_SAT_EN
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
`endif
        return s[15:0];
    endfunction

    // One clock cycle: ROM answers last cycle's address, queue presents last tap's sample.
    task automatic step(input bit s, input logic [15:0] d);
        logic [9:0] a;
        a = coeff_addr;
        @(posedge clk);
        #1;
        coeff      = rom[a];
        smpl_in    = pend;
        pend       = d;
        sequencing = s;
    endtask

    function automatic logic [15:0] ramp_d(input int k);
        return 16'(k * 67 - 30000);
    endfunction

    // Burst of n sequencing-high cycles; model sums the first 1021 taps.
    task automatic burst(input int n, input bit ramp, input bit re_raise);
        longint      acc;
        logic [15:0] d;
        int          last;
        acc = 0;
        last = 0;
        for (int k = 0; k < n; k++) begin
            d = ramp ? ramp_d(k) : dconst;
            if (k < 1021) acc += longint'($signed(d)) * longint'($signed(rom[k]));
            step(1'b1, d);
            last = cyc;
        end
        chk("addr_last_tap", {22'd0, coeff_addr}, (n - 1 < 1020) ? n - 1 : 1020);
        exp_cyc.push_back(last + 4);
        exp_val.push_back(scale(acc));
        step(1'b0, 16'h0000);
        if (re_raise) begin
            step(1'b1, 16'h1234);
            chk("addr_drain_raise", {22'd0, coeff_addr}, 0);
            step(1'b0, 16'h0000);
            for (int i = 0; i < 6; i++) begin
                chk("addr_after_raise", {22'd0, coeff_addr}, 0);
                step(1'b0, 16'h0000);
            end
        end
        for (int i = 0; i < 8; i++) step(1'b0, 16'h0000);
    endtask

    always @(negedge clk) begin
        if (exp_cyc.size() > 0 && exp_cyc[0] == cyc) begin
            chk("vld_pulse", {31'd0, smpl_vld}, 1);
            chk("smpl_out_model", {16'd0, smpl_out}, {16'd0, exp_val[0]});
            void'(exp_cyc.pop_front());
            void'(exp_val.pop_front());
        end else begin
            chk("vld_quiet", {31'd0, smpl_vld}, 0);
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 16'h4000;
        step(1'b0, 16'h0000);
        step(1'b0, 16'h0000);
        chk("rst_smpl_out", {16'd0, smpl_out}, 32'h0000);
        chk("rst_vld", {31'd0, smpl_vld}, 0);
        chk("rst_addr", {22'd0, coeff_addr}, 0);
        #2 rst_n = 1'b1;
        step(1'b0, 16'h0000);

        dconst = 16'h0100;
        burst(4, 1'b0, 1'b0);
        chk("four_tap_literal", {16'd0, smpl_out}, 32'h0200);

        dconst = 16'h4000;
        burst(1, 1'b0, 1'b0);
        chk("one_tap_literal", {16'd0, smpl_out}, 32'h2000);

        dconst = 16'h0100;
        burst(4, 1'b0, 1'b1);
        chk("re_raise_literal", {16'd0, smpl_out}, 32'h0200);

        dconst = 16'h0700;
        for (int k = 0; k < 500; k++) step(1'b1, dconst);
        #2;
        rst_n = 1'b0;
        sequencing = 1'b0;
        pend = 16'h0000;
        #1;
        chk("async_rst_smpl_out", {16'd0, smpl_out}, 32'h0000);
        chk("async_rst_vld", {31'd0, smpl_vld}, 0);
        chk("async_rst_addr", {22'd0, coeff_addr}, 0);
        step(1'b0, 16'h0000);
        step(1'b0, 16'h0000);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0000);
        dconst = 16'h0100;
        burst(4, 1'b0, 1'b0);
        chk("post_abort_literal", {16'd0, smpl_out}, 32'h0200);

        for (int i = 0; i < 1024; i++) rom[i] = 16'h7FFF;
        dconst = 16'h8000;
        burst(1021, 1'b0, 1'b0);
`ifdef LOW_FIR_SAT_EN
        chk("full_len_literal", {16'd0, smpl_out}, 32'h8000);
`else
        chk("full_len_literal", {16'd0, smpl_out}, 32'h83FD);
`endif

        for (int i = 0; i < 1024; i++) rom[i] = 16'(i * 29 + 1000);
        burst(1030, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) step(1'b0, 16'h0000);
        chk("pending_results", exp_cyc.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
